// File: rtl/store_align_pkg.sv
`default_nettype none
`ifndef CONTROL_MACROS_SV
`include "control_macros.sv"
`endif
// ============================================================================
// Module  : store_align_pkg
// Purpose : Shared types and width-code constants for the store aligner.
// Revision: 1.0  initial release
// ============================================================================
package store_align_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } store_state_t;

  // Typed aliases of the control-path width macros.
  localparam logic [2:0] C_WIDTH_32  = `WIDTH_32;
  localparam logic [2:0] C_WIDTH_16S = `WIDTH_16S;
  localparam logic [2:0] C_WIDTH_16U = `WIDTH_16U;
  localparam logic [2:0] C_WIDTH_8S  = `WIDTH_8S;
  localparam logic [2:0] C_WIDTH_8U  = `WIDTH_8U;

endpackage
`default_nettype wire

// File: rtl/control_macros.sv
`ifndef CONTROL_MACROS_SV
`define CONTROL_MACROS_SV
// Load/store width codes shared by the memory-stage control path.
`define WIDTH_8S  3'b000
`define WIDTH_16S 3'b001
`define WIDTH_32  3'b010
`define WIDTH_8U  3'b100
`define WIDTH_16U 3'b101
`endif

// File: rtl/store_lane_shift.sv
`default_nettype none
// ============================================================================
// Module  : store_lane_shift
// Purpose : Combinational byte-lane positioning of store data across a
//           two-word window, with byte-enable generation.
// Revision: 1.0  initial release
// ============================================================================
module store_lane_shift
  import store_align_pkg::*;
(
  input  logic [2:0]  i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_data,
  output logic [7:0]  o_be,
  output logic        o_valid
);

  logic [3:0] w_mask;

  // Width decode to a lane mask; signed/unsigned variants are identical on stores.
  always_comb begin
    w_mask  = 4'b0000;
    o_valid = 1'b1;
    case (i_width)
      C_WIDTH_32:              w_mask = 4'b1111;
      C_WIDTH_16S, C_WIDTH_16U: w_mask = 4'b0011;
      C_WIDTH_8S,  C_WIDTH_8U:  w_mask = 4'b0001;
      default:                 o_valid = 1'b0;
    endcase
  end

  // Shift data and enables into lane position; upper halves spill into the next word.
  always_comb begin
    o_data = {32'b0, i_wdata} << {i_off, 3'b000};
    o_be   = {4'b0, w_mask} << i_off;
  end

endmodule
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module  : store_align
// Purpose : Store-path aligner. Positions store data into byte lanes, builds
//           byte enables and splits word-crossing stores into two beats.
// Revision: 1.0  initial release
// ============================================================================
module store_align
  import store_align_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  width_src_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        done_o,
  output logic        err_o
);

  store_state_t r_state, w_state_nxt;

  logic        r_req_ready, w_req_ready_nxt;
  logic        r_mem_valid, w_mem_valid_nxt;
  logic [31:0] r_mem_addr,  w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_be,    w_mem_be_nxt;
  logic [31:0] r_hi_data,   w_hi_data_nxt;
  logic [3:0]  r_hi_be,     w_hi_be_nxt;
  logic        r_done,      w_done_nxt;
  logic        r_err,       w_err_nxt;

  logic [63:0] w_sh_data;
  logic [7:0]  w_sh_be;
  logic        w_sh_valid;
  logic        w_accept;

  store_lane_shift u_shift (
    .i_width (width_src_i),
    .i_off   (addr_i[1:0]),
    .i_wdata (wdata_i),
    .o_data  (w_sh_data),
    .o_be    (w_sh_be),
    .o_valid (w_sh_valid)
  );

  // Ready is low for the first cycle after reset, so this also gates acceptance then.
  assign w_accept = req_valid_i && r_req_ready;

  // Next-state and next-output decode; every output is produced from a register.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_hi_data_nxt   = r_hi_data;
    w_hi_be_nxt     = r_hi_be;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sh_valid) begin
            w_state_nxt     = FIRST;
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = {addr_i[31:2], 2'b00};
            w_mem_wdata_nxt = w_sh_data[31:0];
            w_mem_be_nxt    = w_sh_be[3:0];
            w_hi_data_nxt   = w_sh_data[63:32];
            w_hi_be_nxt     = w_sh_be[7:4];
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      FIRST: begin
        if (mem_ready_i) begin
          if (r_hi_be != 4'b0000) begin
            w_state_nxt     = SECOND;
            w_mem_addr_nxt  = r_mem_addr + 32'd4;
            w_mem_wdata_nxt = r_hi_data;
            w_mem_be_nxt    = r_hi_be;
          end else begin
            w_state_nxt     = IDLE;
            w_mem_valid_nxt = 1'b0;
            w_mem_addr_nxt  = 32'b0;
            w_mem_wdata_nxt = 32'b0;
            w_mem_be_nxt    = 4'b0;
            w_done_nxt      = 1'b1;
          end
        end
      end
      SECOND: begin
        if (mem_ready_i) begin
          w_state_nxt     = IDLE;
          w_mem_valid_nxt = 1'b0;
          w_mem_addr_nxt  = 32'b0;
          w_mem_wdata_nxt = 32'b0;
          w_mem_be_nxt    = 4'b0;
          w_done_nxt      = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_mem_valid_nxt = 1'b0;
      end
    endcase
    w_req_ready_nxt = (w_state_nxt == IDLE);
  end

  // State and output registers; reset abandons any store in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'b0;
      r_mem_wdata <= 32'b0;
      r_mem_be    <= 4'b0;
      r_hi_data   <= 32'b0;
      r_hi_be     <= 4'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_hi_data   <= w_hi_data_nxt;
      r_hi_be     <= w_hi_be_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign req_ready_o = r_req_ready;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_align.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_align
// Purpose : Directed self-checking bench for store_align with a beat
//           scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_store_align;
  import store_align_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [2:0]  width_src_i = '0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b1;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        done_o;
  logic        err_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  beat_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  store_align dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .width_src_i (width_src_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte reference: byte i of the store lands in absolute lane off+i.
  task automatic push_expected(input logic [31:0] addr, input logic [31:0] data, input int nbytes);
    beat_t b0, b1;
    int lane;
    b0.addr = {addr[31:2], 2'b00};
    b1.addr = b0.addr + 32'd4;
    b0.data = '0; b1.data = '0; b0.be = '0; b1.be = '0;
    for (int i = 0; i < nbytes; i++) begin
      lane = int'(addr[1:0]) + i;
      if (lane < 4) begin
        b0.data[lane*8 +: 8] = data[i*8 +: 8];
        b0.be[lane] = 1'b1;
      end else begin
        b1.data[(lane-4)*8 +: 8] = data[i*8 +: 8];
        b1.be[lane-4] = 1'b1;
      end
    end
    sb_q.push_back(b0);
    if (b1.be != 4'b0000) sb_q.push_back(b1);
  endtask

  // Present one request for a single edge; returns at the following negedge.
  task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] w);
    @(negedge clk_i);
    req_valid_i = 1'b1; addr_i = addr; wdata_i = data; width_src_i = w;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Consume all scoreboard beats, stalling each for `stall` cycles, then check done.
  task automatic drain(input string tag, input int stall);
    beat_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int s = 0; s <= stall; s++) begin
        mem_ready_i = (s == stall);
        check({tag, "_valid"}, 32'(mem_valid_o), 32'd1);
        check({tag, "_addr"},  mem_addr_o,  e.addr);
        check({tag, "_data"},  mem_wdata_o, e.data);
        check({tag, "_be"},    32'(mem_be_o), 32'(e.be));
        check({tag, "_done_early"}, 32'(done_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
      end
    end
    mem_ready_i = 1'b1;
    check({tag, "_done"},     32'(done_o),      32'd1);
    check({tag, "_err"},      32'(err_o),       32'd0);
    check({tag, "_idle_vld"}, 32'(mem_valid_o), 32'd0);
    check({tag, "_ready"},    32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    beat_t e;
    // Reset state
    #2;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_valid", 32'(mem_valid_o), 32'd0);
    check("rst_addr",  mem_addr_o, 32'd0);
    check("rst_data",  mem_wdata_o, 32'd0);
    check("rst_be",    32'(mem_be_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check("rel_ready_low", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("rel_ready_high", 32'(req_ready_o), 32'd1);

    // Aligned word
    push_expected(32'h0000_1000, 32'hDEAD_BEEF, 4);
    send(32'h0000_1000, 32'hDEAD_BEEF, C_WIDTH_32);
    drain("word", 0);

    // Byte lane 2
    push_expected(32'h0000_2002, 32'h0000_00A5, 1);
    send(32'h0000_2002, 32'h0000_00A5, C_WIDTH_8U);
    drain("byte2", 0);

    // Byte lane 3 signed code, upper data bits must be dropped
    push_expected(32'h0000_2103, 32'hFFFF_FF7E, 1);
    send(32'h0000_2103, 32'hFFFF_FF7E, C_WIDTH_8S);
    drain("byte3", 0);

    // Halfword at offset 2 stays in one word
    push_expected(32'h0000_2202, 32'h1234_BEEF, 2);
    send(32'h0000_2202, 32'h1234_BEEF, C_WIDTH_16U);
    drain("half2", 0);

    // Split halfword
    push_expected(32'h0000_3003, 32'h0000_CAFE, 2);
    send(32'h0000_3003, 32'h0000_CAFE, C_WIDTH_16S);
    drain("half3", 0);

    // Split word with address wrap and backpressure
    push_expected(32'hFFFF_FFFE, 32'h1122_3344, 4);
    send(32'hFFFF_FFFE, 32'h1122_3344, C_WIDTH_32);
    drain("wrap", 2);

    // Invalid width code
    send(32'h0000_4000, 32'h5555_AAAA, 3'b011);
    check("inv_err",   32'(err_o), 32'd1);
    check("inv_valid", 32'(mem_valid_o), 32'd0);
    check("inv_ready", 32'(req_ready_o), 32'd1);
    check("inv_done",  32'(done_o), 32'd0);
    @(negedge clk_i);
    check("inv_err_pulse", 32'(err_o), 32'd0);
    check("inv_valid2",    32'(mem_valid_o), 32'd0);

    // Reset during SECOND
    push_expected(32'h0000_5001, 32'hA1B2_C3D4, 4);
    send(32'h0000_5001, 32'hA1B2_C3D4, C_WIDTH_32);
    e = sb_q.pop_front();
    check("rst2_b0_addr", mem_addr_o, e.addr);
    check("rst2_b0_data", mem_wdata_o, e.data);
    @(posedge clk_i);
    @(negedge clk_i);
    e = sb_q.pop_front();
    check("rst2_b1_addr", mem_addr_o, e.addr);
    check("rst2_b1_be",   32'(mem_be_o), 32'(e.be));
    rst_n_i = 1'b0;
    #1;
    check("rst2_valid", 32'(mem_valid_o), 32'd0);
    check("rst2_ready", 32'(req_ready_o), 32'd0);
    check("rst2_addr",  mem_addr_o, 32'd0);
    check("rst2_data",  mem_wdata_o, 32'd0);
    check("rst2_be",    32'(mem_be_o), 32'd0);
    check("rst2_done",  32'(done_o), 32'd0);
    @(negedge clk_i);
    check("rst2_done_hold", 32'(done_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("rst2_ready_back", 32'(req_ready_o), 32'd1);
    check("rst2_no_done",    32'(done_o), 32'd0);

    // Fresh aligned store after reset release
    push_expected(32'h0000_6000, 32'h0BAD_F00D, 4);
    send(32'h0000_6000, 32'h0BAD_F00D, C_WIDTH_32);
    drain("post_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
